// File: rtl/neureka_tcdm_responder.sv
// Responder end of the MP-port split TCDM bus: a shared word memory with per-port
// byte-enabled writes and one-cycle read latency. Define NEUREKA_TCDM_STALL_EN to add LFSR stalls.
module neureka_tcdm_responder #(
  parameter int unsigned MP         = 9,
  parameter int unsigned MEM_WORDS  = 16384,
  parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [MP-1:0]        tcdm_req,
  output logic [MP-1:0]        tcdm_gnt,
  input  logic [MP-1:0][31:0]  tcdm_add,
  input  logic [MP-1:0]        tcdm_wen,
  input  logic [MP-1:0][3:0]   tcdm_be,
  input  logic [MP-1:0][31:0]  tcdm_data,
  output logic [MP-1:0][31:0]  tcdm_r_data,
  output logic [MP-1:0]        tcdm_r_valid,
  output logic [15:0]          err_cnt_o
);

  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  logic stall;

`ifdef NEUREKA_TCDM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= STALL_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[3:0] == 4'h0);
`else
  logic unused_seed;
  assign unused_seed = ^STALL_SEED;
  assign stall       = 1'b0;
`endif

  assign tcdm_gnt = tcdm_req & {MP{~stall}};

  logic [31:0]             mem_q [MEM_WORDS];
  logic [MP-1:0][31:0]     offset;
  logic [MP-1:0][AW-1:0]   idx;
  logic [MP-1:0]           in_range;
  logic [MP-1:0]           accept;
  logic [MP-1:0][31:0]     r_data_d, r_data_q;
  logic [MP-1:0]           r_valid_d, r_valid_q;
  logic [15:0]             err_cnt_d, err_cnt_q;
  logic [16:0]             err_sum;

  // Addresses below BASE_ADDR wrap to huge offsets, so one unsigned compare covers both ends.
  always_comb begin
    offset   = '0;
    idx      = '0;
    in_range = '0;
    accept   = '0;
    for (int i = 0; i < MP; i++) begin
      offset[i]   = tcdm_add[i] - BASE_ADDR;
      in_range[i] = ({1'b0, offset[i]} < MEM_BYTES);
      idx[i]      = offset[i][AW+1:2];
      accept[i]   = tcdm_req[i] & tcdm_gnt[i];
    end
  end

  always_comb begin
    r_data_d  = r_data_q;
    r_valid_d = accept;
    err_sum   = {1'b0, err_cnt_q};
    for (int i = 0; i < MP; i++) begin
      if (accept[i]) begin
        if (!tcdm_wen[i])      r_data_d[i] = 32'h0;
        else if (in_range[i])  r_data_d[i] = mem_q[idx[i]];
        else                   r_data_d[i] = 32'hDEAD_BEEF;
        if (!in_range[i])      err_sum = err_sum + 17'd1;
      end
    end
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data_q  <= '0;
      r_valid_q <= '0;
      err_cnt_q <= '0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Later ports overwrite earlier ones, giving the higher index priority per byte.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < MP; p++) begin
      for (int b = 0; b < 4; b++) begin
        if (accept[p] && !tcdm_wen[p] && in_range[p] && tcdm_be[p][b])
          mem_q[idx[p]][8*b +: 8] <= tcdm_data[p][8*b +: 8];
      end
    end
  end

  assign tcdm_r_data  = r_data_q;
  assign tcdm_r_valid = r_valid_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_neureka_tcdm_responder.sv
// Directed self-checking bench for neureka_tcdm_responder; the stall scenario
// runs only when NEUREKA_TCDM_STALL_EN is defined.
module tb_neureka_tcdm_responder;

  localparam int unsigned MP   = 9;
  localparam int unsigned MW   = 16384;
  localparam logic [31:0] BASE = 32'h1C00_0000;
  localparam logic [15:0] SEED = 16'hACE1;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [MP-1:0]       tcdm_req;
  logic [MP-1:0]       tcdm_gnt;
  logic [MP-1:0][31:0] tcdm_add;
  logic [MP-1:0]       tcdm_wen;
  logic [MP-1:0][3:0]  tcdm_be;
  logic [MP-1:0][31:0] tcdm_data;
  logic [MP-1:0][31:0] tcdm_r_data;
  logic [MP-1:0]       tcdm_r_valid;
  logic [15:0]         err_cnt_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  neureka_tcdm_responder #(
    .MP(MP), .MEM_WORDS(MW), .BASE_ADDR(BASE), .STALL_SEED(SEED)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add),
    .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be), .tcdm_data(tcdm_data),
    .tcdm_r_data(tcdm_r_data), .tcdm_r_valid(tcdm_r_valid), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, chk=%0d", chk_cnt);
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    tcdm_req  = '0;
    tcdm_add  = '0;
    tcdm_wen  = '1;
    tcdm_be   = '0;
    tcdm_data = '0;
  endtask

  task automatic set_port(input int p, input logic wen, input logic [31:0] add,
                          input logic [3:0] be, input logic [31:0] d);
    tcdm_req[p]  = 1'b1;
    tcdm_wen[p]  = wen;
    tcdm_add[p]  = add;
    tcdm_be[p]   = be;
    tcdm_data[p] = d;
  endtask

  // Waits (bounded) for the shared grant, takes the accepting edge, then idles the bus.
  task automatic accept_cycle();
    #1;
    for (int k = 0; k < 64; k++) begin
      if (tcdm_gnt === tcdm_req) break;
      @(posedge clk_i); #1;
    end
    if (tcdm_gnt !== tcdm_req) begin
      chk_cnt++;
      $display("FAIL accept_timeout gnt=%h req=%h", tcdm_gnt, tcdm_req);
    end
    @(posedge clk_i); #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk_i);
    #1;
    chk_cnt++; if (tcdm_r_valid !== '0) $display("FAIL rst_valid got=%h exp=0", tcdm_r_valid); else pass_cnt++;
    chk_cnt++; if (tcdm_r_data !== '0) $display("FAIL rst_data got=%h exp=0", tcdm_r_data); else pass_cnt++;
    chk_cnt++; if (err_cnt_o !== 16'h0) $display("FAIL rst_err got=%h exp=0", err_cnt_o); else pass_cnt++;
    for (int p = 0; p < MP; p++) if (p inside {0, 1, 4, 6, 8}) set_port(p, 1'b1, BASE, 4'hF, 32'h0);
    #1;
    chk_cnt++; if (tcdm_gnt !== 9'h153) $display("FAIL gnt_pattern got=%h exp=153", tcdm_gnt); else pass_cnt++;
    @(posedge clk_i); #1;
    chk_cnt++; if (tcdm_r_valid !== '0) $display("FAIL rst_hold_valid got=%h exp=0", tcdm_r_valid); else pass_cnt++;
    rst_ni = 1'b1;
    clear_inputs();
    @(posedge clk_i); #1;
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, BASE - 32'd4, 4'hF, 32'h0);
    #2 rst_ni = 1'b0;
    @(posedge clk_i); #1;
    chk_cnt++; if (tcdm_r_valid !== '0) $display("FAIL rst_accept_valid got=%h exp=0", tcdm_r_valid); else pass_cnt++;
    chk_cnt++; if (err_cnt_o !== 16'h0) $display("FAIL rst_accept_err got=%h exp=0", err_cnt_o); else pass_cnt++;
    clear_inputs();
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_write_read();
    set_port(0, 1'b0, BASE + 32'h10, 4'hF, 32'h1234_5678);
    accept_cycle();
    chk_cnt++; if (tcdm_r_valid !== 9'h001) $display("FAIL wr_valid got=%h exp=001", tcdm_r_valid); else pass_cnt++;
    chk_cnt++; if (tcdm_r_data[0] !== 32'h0) $display("FAIL wr_rdata got=%h exp=0", tcdm_r_data[0]); else pass_cnt++;
    set_port(0, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    accept_cycle();
    chk_cnt++; if (tcdm_r_valid !== 9'h001) $display("FAIL rd_valid got=%h exp=001", tcdm_r_valid); else pass_cnt++;
    chk_cnt++; if (tcdm_r_data[0] !== 32'h1234_5678) $display("FAIL rd_data got=%h exp=12345678", tcdm_r_data[0]); else pass_cnt++;
    @(posedge clk_i); #1;
    chk_cnt++; if (tcdm_r_valid !== '0) $display("FAIL idle_valid got=%h exp=0", tcdm_r_valid); else pass_cnt++;
    chk_cnt++; if (tcdm_r_data[0] !== 32'h1234_5678) $display("FAIL idle_hold got=%h exp=12345678", tcdm_r_data[0]); else pass_cnt++;
  endtask

  task automatic test_byte_enable();
    set_port(0, 1'b0, BASE + 32'h20, 4'hF, 32'hFFFF_FFFF);
    accept_cycle();
    set_port(0, 1'b0, BASE + 32'h20, 4'b0101, 32'h0);
    accept_cycle();
    set_port(5, 1'b1, BASE + 32'h23, 4'h0, 32'h0);
    accept_cycle();
    chk_cnt++; if (tcdm_r_data[5] !== 32'hFF00_FF00) $display("FAIL be_data got=%h exp=FF00FF00", tcdm_r_data[5]); else pass_cnt++;
  endtask

  task automatic test_priority();
    set_port(0, 1'b0, BASE + 32'h40, 4'hF, 32'hA);
    set_port(8, 1'b0, BASE + 32'h40, 4'hF, 32'hB);
    set_port(2, 1'b0, BASE + 32'h44, 4'hF, 32'h1111_1111);
    set_port(7, 1'b0, BASE + 32'h44, 4'b0011, 32'h2222_2222);
    accept_cycle();
    chk_cnt++; if (tcdm_r_valid !== 9'h185) $display("FAIL prio_valid got=%h exp=185", tcdm_r_valid); else pass_cnt++;
    chk_cnt++; if (tcdm_r_data[8] !== 32'h0) $display("FAIL prio_wr_rdata got=%h exp=0", tcdm_r_data[8]); else pass_cnt++;
    set_port(3, 1'b1, BASE + 32'h40, 4'h0, 32'h0);
    set_port(4, 1'b1, BASE + 32'h44, 4'h0, 32'h0);
    accept_cycle();
    chk_cnt++; if (tcdm_r_data[3] !== 32'h0000_000B) $display("FAIL prio_word got=%h exp=0000000B", tcdm_r_data[3]); else pass_cnt++;
    chk_cnt++; if (tcdm_r_data[4] !== 32'h1111_2222) $display("FAIL prio_bytes got=%h exp=11112222", tcdm_r_data[4]); else pass_cnt++;
  endtask

  task automatic test_rw_same();
    set_port(0, 1'b0, BASE + 32'h50, 4'hF, 32'h5);
    accept_cycle();
    set_port(1, 1'b1, BASE + 32'h50, 4'h0, 32'h0);
    set_port(2, 1'b0, BASE + 32'h50, 4'hF, 32'h7);
    accept_cycle();
    chk_cnt++; if (tcdm_r_data[1] !== 32'h5) $display("FAIL rw_old got=%h exp=5", tcdm_r_data[1]); else pass_cnt++;
    chk_cnt++; if (tcdm_r_data[2] !== 32'h0) $display("FAIL rw_wr_rdata got=%h exp=0", tcdm_r_data[2]); else pass_cnt++;
    set_port(1, 1'b1, BASE + 32'h50, 4'h0, 32'h0);
    accept_cycle();
    chk_cnt++; if (tcdm_r_data[1] !== 32'h7) $display("FAIL rw_new got=%h exp=7", tcdm_r_data[1]); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    set_port(0, 1'b0, BASE, 4'hF, 32'hCAFE_F00D);
    set_port(1, 1'b0, BASE + 4 * MW - 4, 4'hF, 32'h0000_600D);
    accept_cycle();
    chk_cnt++; if (err_cnt_o !== 16'd0) $display("FAIL oob_err0 got=%0d exp=0", err_cnt_o); else pass_cnt++;
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, BASE - 32'd4, 4'h0, 32'h0);
    accept_cycle();
    chk_cnt++; if (tcdm_r_valid !== 9'h007) $display("FAIL oob_valid got=%h exp=007", tcdm_r_valid); else pass_cnt++;
    for (int p = 0; p < 3; p++) begin
      chk_cnt++;
      if (tcdm_r_data[p] !== 32'hDEAD_BEEF) $display("FAIL oob_data port=%0d got=%h exp=DEADBEEF", p, tcdm_r_data[p]);
      else pass_cnt++;
    end
    chk_cnt++; if (err_cnt_o !== 16'd3) $display("FAIL oob_err3 got=%0d exp=3", err_cnt_o); else pass_cnt++;
    set_port(4, 1'b0, BASE + 4 * MW, 4'hF, 32'h0);
    accept_cycle();
    chk_cnt++; if (err_cnt_o !== 16'd4) $display("FAIL oob_err4 got=%0d exp=4", err_cnt_o); else pass_cnt++;
    set_port(0, 1'b1, BASE, 4'h0, 32'h0);
    set_port(6, 1'b1, BASE + 4 * MW - 4, 4'h0, 32'h0);
    accept_cycle();
    chk_cnt++; if (tcdm_r_data[0] !== 32'hCAFE_F00D) $display("FAIL oob_dropped got=%h exp=CAFEF00D", tcdm_r_data[0]); else pass_cnt++;
    chk_cnt++; if (tcdm_r_data[6] !== 32'h0000_600D) $display("FAIL last_word got=%h exp=0000600D", tcdm_r_data[6]); else pass_cnt++;
    chk_cnt++; if (err_cnt_o !== 16'd4) $display("FAIL inrange_noerr got=%0d exp=4", err_cnt_o); else pass_cnt++;
  endtask

  task automatic test_lockstep();
    logic [MP-1:0][31:0] exp_all;
    exp_all = {MP{32'h1234_5678}};
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    accept_cycle();
    chk_cnt++; if (tcdm_r_valid !== '1) $display("FAIL lock_valid got=%h exp=1FF", tcdm_r_valid); else pass_cnt++;
    chk_cnt++; if (tcdm_r_data !== exp_all) $display("FAIL lock_data got=%h", tcdm_r_data); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int start;
    start = cyc;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) set_port(0, 1'b0, BASE + 32'h100 + 32'(4 * k), 4'hF, 32'hB0 + 32'(k));
      else       set_port(0, 1'b1, BASE + 32'h100 + 32'(4 * (k - 4)), 4'h0, 32'h0);
      accept_cycle();
      chk_cnt++;
      if (tcdm_r_valid[0] !== 1'b1) $display("FAIL b2b_valid step=%0d got=%b exp=1", k, tcdm_r_valid[0]);
      else pass_cnt++;
      chk_cnt++;
      if (tcdm_r_data[0] !== ((k < 4) ? 32'h0 : 32'hB0 + 32'(k - 4)))
        $display("FAIL b2b_data step=%0d got=%h exp=%h", k, tcdm_r_data[0], (k < 4) ? 32'h0 : 32'hB0 + 32'(k - 4));
      else pass_cnt++;
    end
`ifndef NEUREKA_TCDM_STALL_EN
    chk_cnt++; if (cyc - start !== 8) $display("FAIL b2b_cycles got=%0d exp=8", cyc - start); else pass_cnt++;
`endif
  endtask

  task automatic test_err_saturate();
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, BASE - 32'd4, 4'h0, 32'h0);
`ifndef NEUREKA_TCDM_STALL_EN
    repeat (7281) @(posedge clk_i);
    #1;
    chk_cnt++; if (err_cnt_o !== 16'd65533) $display("FAIL err_near got=%0d exp=65533", err_cnt_o); else pass_cnt++;
    @(posedge clk_i); #1;
    chk_cnt++; if (err_cnt_o !== 16'hFFFF) $display("FAIL err_sat got=%h exp=FFFF", err_cnt_o); else pass_cnt++;
`else
    repeat (9000) @(posedge clk_i);
    #1;
`endif
    repeat (2) @(posedge clk_i);
    #1;
    chk_cnt++; if (err_cnt_o !== 16'hFFFF) $display("FAIL err_hold got=%h exp=FFFF", err_cnt_o); else pass_cnt++;
    clear_inputs();
    @(posedge clk_i); #1;
  endtask

  task automatic test_mem_retained();
    rst_ni = 1'b0;
    #1;
    chk_cnt++; if (err_cnt_o !== 16'h0) $display("FAIL rst2_err got=%h exp=0", err_cnt_o); else pass_cnt++;
    chk_cnt++; if (tcdm_r_data !== '0) $display("FAIL rst2_data got=%h exp=0", tcdm_r_data); else pass_cnt++;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    set_port(0, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    accept_cycle();
    chk_cnt++; if (tcdm_r_data[0] !== 32'h1234_5678) $display("FAIL mem_kept got=%h exp=12345678", tcdm_r_data[0]); else pass_cnt++;
  endtask

`ifdef NEUREKA_TCDM_STALL_EN
  task automatic test_stall();
    logic [15:0]   m;
    logic [MP-1:0] prev_gnt, exp_gnt;
    int first_model, first_dut;
    first_model = -1;
    first_dut   = -1;
    rst_ni = 1'b0;
    clear_inputs();
    @(posedge clk_i); #1;
    rst_ni   = 1'b1;
    m        = SEED;
    prev_gnt = '0;
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, BASE + 32'(4 * p), 4'h0, 32'h0);
    for (int c = 0; c < 1000; c++) begin
      exp_gnt = (m[3:0] == 4'h0) ? '0 : '1;
      if (m[3:0] == 4'h0 && first_model < 0) first_model = c;
      if (tcdm_gnt !== '1 && first_dut < 0) first_dut = c;
      chk_cnt++;
      if (tcdm_gnt !== exp_gnt) $display("FAIL stall_gnt cyc=%0d got=%h exp=%h", c, tcdm_gnt, exp_gnt);
      else pass_cnt++;
      chk_cnt++;
      if (tcdm_r_valid !== prev_gnt) $display("FAIL stall_latency cyc=%0d got=%h exp=%h", c, tcdm_r_valid, prev_gnt);
      else pass_cnt++;
      prev_gnt = tcdm_gnt;
      @(posedge clk_i); #1;
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end
    chk_cnt++;
    if (first_model < 0 || first_dut !== first_model)
      $display("FAIL first_stall got=%0d exp=%0d", first_dut, first_model);
    else pass_cnt++;
    clear_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_priority();
    test_rw_same();
    test_out_of_range();
    test_lockstep();
    test_back_to_back();
    test_err_saturate();
    test_mem_retained();
`ifdef NEUREKA_TCDM_STALL_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
